st_c2h_gen: RTL and testbench

Stream C2H pattern generator for the CPM QDMA example design. It produces AXI-Stream packets toward the QDMA C2H streaming interface. Each packet carries the same incrementing 16-bit pattern that the H2C stream checker verifies, so host software can compare both directions against one reference. The block is started by the control register's run bit and reports packet count and completion back to the register file.

---
 rtl/st_c2h_gen.sv | 159 +++++++++++++++
 tb/tb_st_c2h_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/st_c2h_gen.sv
// Stream C2H pattern generator: emits AXI-Stream packets of incrementing 16-bit words
// toward the QDMA C2H interface, started by a rising edge of control_run.
module st_c2h_gen #(
  parameter int unsigned BIT_WIDTH = 64,
  parameter int unsigned QID_WIDTH = 11
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 control_run,
  input  logic [31:0]          c2h_txr_size,
  input  logic [15:0]          c2h_num_pkt,
  input  logic [QID_WIDTH-1:0] c2h_qid_in,
  input  logic                 c2h_tready,
  output logic [BIT_WIDTH-1:0] c2h_tdata,
  output logic                 c2h_tvalid,
  output logic                 c2h_tlast,
  output logic [5:0]           c2h_mty,
  output logic [QID_WIDTH-1:0] c2h_qid,
  output logic [15:0]          c2h_len,
  output logic [31:0]          c2h_pkt_count,
  output logic                 c2h_done,
  output logic                 c2h_err
);

  localparam int unsigned Bytes     = BIT_WIDTH / 8;
  localparam int unsigned Words     = BIT_WIDTH / 16;
  localparam int unsigned ByteShift = $clog2(Bytes);

  typedef enum logic [2:0] {StIdle, StArm, StSend, StGap, StDone} state_e;

  state_e      state_q;
  logic        run_q, run_prev_q;
  logic [15:0] num_pkt_q;
  logic [15:0] beats_q;
  logic [15:0] beat_idx_q;
  logic [15:0] base_q;
  logic [5:0]  mty_last_q;

  logic [15:0] len_in;
  logic [15:0] beats_calc;
  logic [5:0]  mty_calc;
  logic [15:0] base_next;
  logic        next_is_last;
  logic        run_rise;
  logic        run_finished;
  logic        unused_size;

  function automatic logic [BIT_WIDTH-1:0] pattern(input logic [15:0] base);
    logic [BIT_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < int'(Words); i++) begin
      d[16*i +: 16] = base + 16'(i);
    end
    return d;
  endfunction

  always_comb begin
    len_in       = c2h_txr_size[15:0];
    beats_calc   = 16'((17'(len_in) + 17'(Bytes - 1)) >> ByteShift);
    mty_calc     = 6'(22'(beats_calc) * 22'(Bytes) - 22'(len_in));
    base_next    = base_q + 16'(Words);
    next_is_last = (beat_idx_q + 16'd2) == beats_q;
    run_rise     = run_q & ~run_prev_q;
    run_finished = ((num_pkt_q != 16'd0) && (c2h_pkt_count == {16'd0, num_pkt_q}))
                   || !control_run;
    unused_size  = ^c2h_txr_size[31:16];
  end

  // Edge detector resets to "high" so a run held high across reset does not restart.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q       <= StIdle;
      run_q         <= 1'b1;
      run_prev_q    <= 1'b1;
      num_pkt_q     <= '0;
      beats_q       <= '0;
      beat_idx_q    <= '0;
      base_q        <= '0;
      mty_last_q    <= '0;
      c2h_tdata     <= '0;
      c2h_tvalid    <= 1'b0;
      c2h_tlast     <= 1'b0;
      c2h_mty       <= '0;
      c2h_qid       <= '0;
      c2h_len       <= '0;
      c2h_pkt_count <= '0;
      c2h_done      <= 1'b0;
      c2h_err       <= 1'b0;
    end else begin
      run_q      <= control_run;
      run_prev_q <= run_q;
      unique case (state_q)
        StIdle: begin
          if (run_rise) state_q <= StArm;
        end
        StArm: begin
          c2h_len       <= len_in;
          c2h_qid       <= c2h_qid_in;
          num_pkt_q     <= c2h_num_pkt;
          beats_q       <= beats_calc;
          mty_last_q    <= mty_calc;
          c2h_pkt_count <= '0;
          beat_idx_q    <= '0;
          base_q        <= '0;
          if (len_in == 16'd0) begin
            c2h_err  <= 1'b1;
            c2h_done <= 1'b1;
            state_q  <= StDone;
          end else begin
            c2h_err    <= 1'b0;
            c2h_tvalid <= 1'b1;
            c2h_tdata  <= pattern(16'd0);
            c2h_tlast  <= (beats_calc == 16'd1);
            c2h_mty    <= (beats_calc == 16'd1) ? mty_calc : 6'd0;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (c2h_tready) begin
            if (c2h_tlast) begin
              c2h_tvalid    <= 1'b0;
              c2h_tlast     <= 1'b0;
              c2h_mty       <= '0;
              c2h_pkt_count <= c2h_pkt_count + 32'd1;
              base_q        <= '0;
              state_q       <= StGap;
            end else begin
              base_q     <= base_next;
              beat_idx_q <= beat_idx_q + 16'd1;
              c2h_tdata  <= pattern(base_next);
              c2h_tlast  <= next_is_last;
              c2h_mty    <= next_is_last ? mty_last_q : 6'd0;
            end
          end
        end
        StGap: begin
          base_q     <= '0;
          beat_idx_q <= '0;
          if (run_finished) begin
            c2h_done <= 1'b1;
            state_q  <= StDone;
          end else begin
            c2h_tvalid <= 1'b1;
            c2h_tdata  <= pattern(16'd0);
            c2h_tlast  <= (beats_q == 16'd1);
            c2h_mty    <= (beats_q == 16'd1) ? mty_last_q : 6'd0;
            state_q    <= StSend;
          end
        end
        StDone: begin
          c2h_done <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_st_c2h_gen.sv
// Directed bench for st_c2h_gen: 64-bit and 512-bit instances, hand-computed expectations.
module tb_st_c2h_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, run5 = 1'b0;
  logic [31:0] txr_size = 32'd0;
  logic [15:0] num_pkt = 16'd0;
  logic [10:0] qid_in = 11'd0;
  logic        tready = 1'b0, tready5 = 1'b0;

  logic [63:0]  tdata;
  logic         tvalid, tlast, done, err;
  logic [5:0]   mty;
  logic [10:0]  qid;
  logic [15:0]  len;
  logic [31:0]  pkt_count;

  logic [511:0] tdata5;
  logic         tvalid5, tlast5, done5, err5;
  logic [5:0]   mty5;
  logic [10:0]  qid5;
  logic [15:0]  len5;
  logic [31:0]  pkt_count5;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  st_c2h_gen #(.BIT_WIDTH(64), .QID_WIDTH(11)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .control_run(run), .c2h_txr_size(txr_size),
    .c2h_num_pkt(num_pkt), .c2h_qid_in(qid_in), .c2h_tready(tready), .c2h_tdata(tdata),
    .c2h_tvalid(tvalid), .c2h_tlast(tlast), .c2h_mty(mty), .c2h_qid(qid), .c2h_len(len),
    .c2h_pkt_count(pkt_count), .c2h_done(done), .c2h_err(err)
  );

  st_c2h_gen #(.BIT_WIDTH(512), .QID_WIDTH(11)) dut512 (
    .axi_aclk(clk), .axi_aresetn(rst_n), .control_run(run5), .c2h_txr_size(txr_size),
    .c2h_num_pkt(num_pkt), .c2h_qid_in(qid_in), .c2h_tready(tready5), .c2h_tdata(tdata5),
    .c2h_tvalid(tvalid5), .c2h_tlast(tlast5), .c2h_mty(mty5), .c2h_qid(qid5), .c2h_len(len5),
    .c2h_pkt_count(pkt_count5), .c2h_done(done5), .c2h_err(err5)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat64(input int base);
    logic [63:0] d;
    for (int i = 0; i < 4; i++) d[16*i +: 16] = 16'(base + i);
    return d;
  endfunction

  function automatic logic [511:0] pat512(input int base);
    logic [511:0] d;
    for (int i = 0; i < 32; i++) d[16*i +: 16] = 16'(base + i);
    return d;
  endfunction

  // Receives one packet on the 64-bit instance; drop_at = beat index whose handshake drops run.
  task automatic recv_pkt(input int nbeats, input int exp_mty, input bit rnd, input int drop_at);
    int b = 0;
    int cyc = 0;
    bit stalled = 0;
    bit rdy;
    while (b < nbeats && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stalled) check("valid_held", tvalid, 1);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tready = rdy;
      stalled = 0;
      if (tvalid) begin
        check("data", tdata, pat64(b * 4));
        check("last", tlast, (b == nbeats - 1));
        check("mty", mty, (b == nbeats - 1) ? exp_mty : 0);
        if (rdy) begin
          if (b == drop_at) run = 1'b0;
          b++;
        end else begin
          stalled = 1;
        end
      end
    end
    if (b < nbeats) check("pkt_timeout", b, nbeats);
    tready = 1'b1;
  endtask

  task automatic wait_done(input int budget, input logic [31:0] exp_cnt);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        check("count_at_done", pkt_count, exp_cnt);
      end
    end
    check("done_seen", seen, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int seen_valid;
    int done_cnt;
    int done_at;
    int found;

    // Reset state
    #12;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_count", pkt_count, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);

    // L=20, N=1, full rate: exact latency and per-cycle beat timing
    txr_size = 32'd20; num_pkt = 16'd1; qid_in = 11'd5; tready = 1'b1;
    run = 1'b1;
    @(negedge clk); check("lat_e", tvalid, 0);
    @(negedge clk); check("lat_arm", tvalid, 0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      check("t1_valid", tvalid, 1);
      check("t1_data", tdata, pat64(b * 4));
      check("t1_last", tlast, (b == 2));
      check("t1_mty", mty, (b == 2) ? 4 : 0);
      qid_in = 11'd7; txr_size = 32'd100;
    end
    @(negedge clk);
    check("t1_gap_valid", tvalid, 0);
    check("t1_count", pkt_count, 1);
    check("t1_gap_done", done, 0);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_qid", qid, 5);
    check("t1_len", len, 20);
    @(negedge clk);
    check("t1_done_off", done, 0);
    run = 1'b0;
    idle_cycles(3);

    // L=16, N=3, random ready
    txr_size = 32'd16; num_pkt = 16'd3;
    run = 1'b1;
    for (int p = 0; p < 3; p++) recv_pkt(2, 0, 1'b1, -1);
    wait_done(20, 3);
    check("t2_count", pkt_count, 3);
    run = 1'b0;
    idle_cycles(3);

    // 512-bit, L=65, N=1
    txr_size = 32'd65; num_pkt = 16'd1; tready5 = 1'b1;
    run5 = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (tvalid5) found = 1;
    end
    check("w_start", found, 1);
    for (int c = 0; c < 8; c++) check("w_b0", tdata5[64*c +: 64], pat512(0) >> (64 * c));
    check("w_b0_last", tlast5, 0);
    check("w_b0_mty", mty5, 0);
    @(negedge clk);
    check("w_b1_valid", tvalid5, 1);
    for (int c = 0; c < 8; c++) check("w_b1", tdata5[64*c +: 64], pat512(32) >> (64 * c));
    check("w_b1_last", tlast5, 1);
    check("w_b1_mty", mty5, 63);
    idle_cycles(2);
    check("w_done", done5, 1);
    check("w_count", pkt_count5, 1);
    run5 = 1'b0;
    idle_cycles(3);

    // L=0: error path
    txr_size = 32'd0; num_pkt = 16'd1;
    run = 1'b1;
    seen_valid = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tvalid) seen_valid = 1;
      if (done) begin done_cnt++; done_at = i; end
    end
    check("z_no_valid", seen_valid, 0);
    check("z_done_cnt", done_cnt, 1);
    check("z_done_at", done_at, 2);
    check("z_err", err, 1);
    run = 1'b0;
    idle_cycles(3);
    check("z_err_sticky", err, 1);

    // N=0 continuous, L=64, run drops on beat 5 of packet 2
    txr_size = 32'd64; num_pkt = 16'd0;
    run = 1'b1;
    recv_pkt(8, 0, 1'b0, -1);
    check("c_err_cleared", err, 0);
    recv_pkt(8, 0, 1'b0, 4);
    wait_done(20, 2);
    idle_cycles(3);

    // Reset mid-packet with run held high
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found < 3; i++) begin
      @(negedge clk);
      if (tvalid) found++;
    end
    check("r_running", found, 3);
    rst_n = 1'b0;
    #1;
    check("r_tvalid", tvalid, 0);
    check("r_tdata", tdata, 0);
    check("r_tlast", tlast, 0);
    check("r_mty", mty, 0);
    check("r_qid", qid, 0);
    check("r_len", len, 0);
    check("r_count", pkt_count, 0);
    check("r_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tvalid) seen_valid = 1;
    end
    check("r_no_restart", seen_valid, 0);
    run = 1'b0;
    idle_cycles(2);
    run = 1'b1;
    recv_pkt(8, 0, 1'b0, 7);
    wait_done(20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
